// File: rtl/change_dispenser.sv
// Change-payout controller: pays `i_amount` cents out to the coin hopper, one coin per
// request/ack handshake, always choosing the largest coin that fits.
// Optional build macro CHANGE_INVENTORY_EN adds per-denomination stock tracking.
module change_dispenser #(
    parameter int         AMT_W       = 10,
    parameter int         GAP_CYCLES  = 4,
    parameter int         ACK_TIMEOUT = 255,
    parameter logic [7:0] INV_INIT    = 8'd20
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [AMT_W-1:0] i_amount,
    input  logic             i_hopper_ack_n,
`ifdef CHANGE_INVENTORY_EN
    input  logic             i_restock_n,
    output logic [4:0]       o_inv_empty,
    output logic             o_short,
`endif
    output logic             o_coin_req,
    output logic [4:0]       o_coin_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_fault,
    output logic [AMT_W-1:0] o_remaining,
    output logic [5:0]       o_coins_paid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    function automatic logic [AMT_W-1:0] coin_value(input logic [4:0] sel);
        logic [AMT_W-1:0] v;
        case (sel)
            5'b00001: v = AMT_W'(5);
            5'b00010: v = AMT_W'(10);
            5'b00100: v = AMT_W'(25);
            5'b01000: v = AMT_W'(50);
            5'b10000: v = AMT_W'(100);
            default:  v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [AMT_W-1:0] sub_floor(input logic [AMT_W-1:0] a,
                                                   input logic [AMT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    function automatic logic [5:0] sat_inc6(input logic [5:0] a);
        return (a == 6'h3F) ? a : (a + 6'd1);
    endfunction

    logic [2:0]       r_state;
    logic             r_coin_req;
    logic [4:0]       r_coin_sel;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_fault;
    logic [AMT_W-1:0] r_remaining;
    logic [5:0]       r_coins_paid;
    logic [TMO_W-1:0] r_tmo;
    logic [GAP_W-1:0] r_gap;

    logic [4:0]       w_has_stock;
    logic [4:0]       w_sel;
    logic             w_amt_ok;
    logic             w_ack_in_req;

    assign w_amt_ok     = ((i_amount % AMT_W'(5)) == '0);
    assign w_ack_in_req = (r_state == S_REQ) && !i_hopper_ack_n;

`ifdef CHANGE_INVENTORY_EN
    logic [4:0][7:0] r_stock;
    logic [4:0][7:0] w_stock_nxt;
    logic [4:0]      r_inv_empty;
    logic            r_short;

    // Restock only lands while idle so a payout never sees its stock change mid-flight
    always_comb begin
        w_stock_nxt = r_stock;
        if ((r_state == S_IDLE) && !i_restock_n) begin
            for (int i = 0; i < 5; i++) w_stock_nxt[i] = INV_INIT;
        end else if (w_ack_in_req) begin
            for (int i = 0; i < 5; i++) begin
                if (r_coin_sel[i] && (r_stock[i] != 8'd0)) w_stock_nxt[i] = r_stock[i] - 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 5; i++) r_stock[i] <= INV_INIT;
            r_inv_empty <= {5{INV_INIT == 8'd0}};
        end else begin
            r_stock <= w_stock_nxt;
            for (int i = 0; i < 5; i++) r_inv_empty[i] <= (w_stock_nxt[i] == 8'd0);
        end
    end

    always_comb begin
        w_has_stock = '0;
        for (int i = 0; i < 5; i++) w_has_stock[i] = (r_stock[i] != 8'd0);
    end

    assign o_inv_empty = r_inv_empty;
    assign o_short     = r_short;
`else
    assign w_has_stock = 5'b11111;
`endif

    // Ascending scan so the largest fitting, stocked coin wins
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < 5; i++) begin
            if ((coin_value(5'(1) << i) <= r_remaining) && w_has_stock[i]) w_sel = 5'(1) << i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_coin_req   <= 1'b0;
            r_coin_sel   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_fault      <= 1'b0;
            r_remaining  <= '0;
            r_coins_paid <= '0;
            r_tmo        <= '0;
            r_gap        <= '0;
`ifdef CHANGE_INVENTORY_EN
            r_short      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
`ifdef CHANGE_INVENTORY_EN
            r_short <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (w_amt_ok) begin
                            r_remaining  <= i_amount;
                            r_coins_paid <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= (i_amount == '0) ? S_DONE : S_SELECT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                // No selectable coin only happens when stock has run out
                S_SELECT: begin
                    if (w_sel != '0) begin
                        r_coin_sel <= w_sel;
                        r_coin_req <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= S_REQ;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_REQ: begin
                    if (!i_hopper_ack_n) begin
                        r_remaining  <= sub_floor(r_remaining, coin_value(r_coin_sel));
                        r_coins_paid <= sat_inc6(r_coins_paid);
                        r_coin_req   <= 1'b0;
                        r_coin_sel   <= '0;
                        r_state      <= S_RELEASE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_coin_req <= 1'b0;
                        r_coin_sel <= '0;
                        r_busy     <= 1'b0;
                        r_fault    <= 1'b1;
                        r_state    <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (i_hopper_ack_n) begin
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= (r_remaining == '0) ? S_DONE : S_SELECT;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
`ifdef CHANGE_INVENTORY_EN
                    r_short <= (r_remaining != '0);
`endif
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_coin_req <= 1'b0;
                    r_coin_sel <= '0;
                    r_busy     <= 1'b0;
                    r_fault    <= 1'b1;
                end
                default: begin
                    r_coin_req <= 1'b0;
                    r_coin_sel <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_coin_req   = r_coin_req;
    assign o_coin_sel   = r_coin_sel;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_fault      = r_fault;
    assign o_remaining  = r_remaining;
    assign o_coins_paid = r_coins_paid;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed + randomized bench for change_dispenser against a greedy-payout reference model.
module tb_change_dispenser;

    localparam int AMT_W = 10;
    localparam int GAP   = 4;
    localparam int TMO   = 255;
`ifdef CHANGE_INVENTORY_EN
    localparam logic [7:0] INV = 8'd1;
`else
    localparam logic [7:0] INV = 8'd20;
`endif

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             ack_n;
    logic             coin_req;
    logic [4:0]       coin_sel;
    logic             busy;
    logic             done;
    logic             err;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [5:0]       coins_paid;
`ifdef CHANGE_INVENTORY_EN
    logic             restock_n;
    logic [4:0]       inv_empty;
    logic             short_o;
`endif

    change_dispenser #(
        .AMT_W(AMT_W), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO), .INV_INIT(INV)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_amount(amount),
        .i_hopper_ack_n(ack_n),
`ifdef CHANGE_INVENTORY_EN
        .i_restock_n(restock_n), .o_inv_empty(inv_empty), .o_short(short_o),
`endif
        .o_coin_req(coin_req), .o_coin_sel(coin_sel), .o_busy(busy), .o_done(done),
        .o_err(err), .o_fault(fault), .o_remaining(remaining), .o_coins_paid(coins_paid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int denom[5] = '{5, 10, 25, 50, 100};
    int stock[5];
    int exp_rem  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_restock();
        for (int i = 0; i < 5; i++) stock[i] = (INV == 8'd20) ? 100000 : int'(INV);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        chk("rst_coin_req", 32'(coin_req), 0);
        chk("rst_coin_sel", 32'(coin_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_coins_paid", 32'(coins_paid), 0);
        reset_n = 1'b1;
        model_restock();
        exp_rem = 0;
    endtask

    task automatic wait_req();
        int w = 0;
        while (!coin_req && w < 40) begin
            tick();
            w++;
        end
        chk("req_wait", 32'(coin_req), 1);
    endtask

    // Full payout: the model computes the greedy coin list from the amount and stock.
    task automatic run_payout(input int amt, input int dly);
        int coins[$];
        int owed;
        int w;
        int hold;
        bit seen_req;
        owed = amt;
        for (int i = 4; i >= 0; i--) begin
            while (owed >= denom[i] && stock[i] > 0) begin
                coins.push_back(i);
                owed -= denom[i];
                stock[i]--;
            end
        end
        start = 1'b1;
        amount = AMT_W'(amt);
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        owed = amt;
        foreach (coins[k]) begin
            wait_req();
            chk("coin_sel", 32'(coin_sel), 32'(1 << coins[k]));
            chk("rem_at_req", 32'(remaining), 32'(owed));
            for (int d = 1; d < dly; d++) tick();
            chk("req_held", 32'({coin_req, coin_sel}), 32'({1'b1, 5'(1 << coins[k])}));
            ack_n = 1'b0;
            tick();
            owed -= denom[coins[k]];
            chk("req_drop", 32'(coin_req), 0);
            chk("rem_after_ack", 32'(remaining), 32'(owed));
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) tick();
            chk("paid_after_ack", 32'(coins_paid), 32'(k + 1));
            ack_n = 1'b1;
        end
        w = 0;
        seen_req = 1'b0;
        while (!done && w < 40) begin
            seen_req |= coin_req;
            tick();
            w++;
        end
        chk("done_wait", 32'(done), 1);
        chk("no_extra_req", 32'(seen_req | coin_req), 0);
        chk("busy_at_done", 32'(busy), 0);
        chk("paid_final", 32'(coins_paid), 32'(coins.size()));
        chk("rem_final", 32'(remaining), 32'(owed));
`ifdef CHANGE_INVENTORY_EN
        chk("short_flag", 32'(short_o), 32'(owed != 0));
`endif
        tick();
        chk("done_one_cycle", 32'(done), 0);
        exp_rem = owed;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        reset_n = 1'b0;
        start = 1'b0;
        amount = '0;
        ack_n = 1'b1;
`ifdef CHANGE_INVENTORY_EN
        restock_n = 1'b1;
`endif
        tick();
        do_reset();

        // 65 cents: 50, 10, 5
        run_payout(65, 3);

        // zero amount: done two edges after start, no coin
        start = 1'b1;
        amount = '0;
        tick();
        start = 1'b0;
        chk("zero_done_early", 32'(done), 0);
        tick();
        chk("zero_done", 32'(done), 1);
        chk("zero_req", 32'(coin_req), 0);
        chk("zero_paid", 32'(coins_paid), 0);
        tick();
        chk("zero_done_off", 32'(done), 0);

        // rejected amount, then a good one
        start = 1'b1;
        amount = AMT_W'(37);
        tick();
        start = 1'b0;
        chk("err_pulse", 32'(err), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_rem", 32'(remaining), 32'(exp_rem));
        tick();
        chk("err_off", 32'(err), 0);
        run_payout(10, 2);

        // hopper never acks
        do_reset();
        start = 1'b1;
        amount = AMT_W'(100);
        tick();
        start = 1'b0;
        tick();
        chk("tmo_req", 32'({coin_req, coin_sel}), 32'({1'b1, 5'b10000}));
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", 32'({fault, coin_req}), 32'({1'b0, 1'b1}));
        tick();
        chk("tmo_fault", 32'(fault), 1);
        chk("tmo_req_off", 32'({coin_req, coin_sel}), 0);
        chk("tmo_rem", 32'(remaining), 100);
        chk("tmo_busy", 32'(busy), 0);
        start = 1'b1;
        amount = AMT_W'(10);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("fault_sticky", 32'({fault, coin_req, busy}), 32'(3'b100));
        chk("fault_rem", 32'(remaining), 100);
        do_reset();

        // reset while waiting for the second coin of 185
        start = 1'b1;
        amount = AMT_W'(185);
        tick();
        start = 1'b0;
        wait_req();
        chk("r5_first", 32'(coin_sel), 32'(5'b10000));
        ack_n = 1'b0;
        tick();
        ack_n = 1'b1;
        wait_req();
        chk("r5_second", 32'(coin_sel), 32'(5'b01000));
        do_reset();
        ack_n = 1'b0;
        tick();
        tick();
        chk("r5_ack_ignored", 32'({coin_req, busy}), 0);
        chk("r5_paid", 32'(coins_paid), 0);
        chk("r5_rem", 32'(remaining), 0);
        ack_n = 1'b1;
        tick();

`ifdef CHANGE_INVENTORY_EN
        do_reset();
        run_payout(90, 2);
        chk("inv_empty", 32'(inv_empty), 32'(5'h0F));
        run_payout(5, 1);
        restock_n = 1'b0;
        tick();
        restock_n = 1'b1;
        model_restock();
        chk("restock", 32'(inv_empty), 0);
`endif

        // random legal and illegal amounts
        for (int n = 0; n < 16; n++) begin
            run_payout(5 * $urandom_range(0, 199), $urandom_range(1, 4));
            if (n % 4 == 0) begin
                a = 5 * $urandom_range(0, 198) + $urandom_range(1, 4);
                start = 1'b1;
                amount = AMT_W'(a);
                tick();
                start = 1'b0;
                chk("rand_err", 32'({err, busy}), 32'(2'b10));
                chk("rand_err_rem", 32'(remaining), 32'(exp_rem));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
